// File: rtl/edge_update_queue.sv
// Edge update queue: assembles two-word Avalon edge updates and buffers
// them in a FWFT FIFO feeding the arbitrage Container.
module edge_update_queue #(
  parameter int NODE_BITS   = 5,
  parameter int WEIGHT_BITS = 32,
  parameter int DEPTH       = 16,
  parameter int CNT_BITS    = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   chipselect,
  input  logic                   write,
  input  logic                   read,
  input  logic [2:0]             address,
  input  logic [WEIGHT_BITS-1:0] writedata,
  output logic [31:0]            readdata,
  output logic                   upd_valid,
  input  logic                   upd_ready,
  output logic [NODE_BITS-1:0]   upd_src,
  output logic [NODE_BITS-1:0]   upd_dst,
  output logic [WEIGHT_BITS-1:0] upd_e,
  output logic [CNT_BITS-1:0]    count,
  output logic                   overflow,
  output logic                   seq_err
);

  localparam int PTR_BITS = $clog2(DEPTH);
  localparam int ENT_BITS = 2*NODE_BITS + WEIGHT_BITS;

  logic [ENT_BITS-1:0]  mem [DEPTH];
  logic [PTR_BITS-1:0]  wr_ptr;
  logic [PTR_BITS-1:0]  rd_ptr;
  logic                 pending;
  logic [NODE_BITS-1:0] pend_src;
  logic [NODE_BITS-1:0] pend_dst;

  logic        wr_en;
  logic        flush;
  logic        wr_w;
  logic        full;
  logic        push;
  logic        pop;
  logic        drop_full;
  logic        drop_seq;
  logic [31:0] status;

  always_comb begin
    wr_en     = chipselect && write;
    flush     = wr_en && (address == 3'd3);
    wr_w      = wr_en && (address == 3'd1);
    full      = (count == CNT_BITS'(DEPTH));
    push      = wr_w && pending && !full;
    drop_full = wr_w && pending && full;
    drop_seq  = wr_w && !pending;
    pop       = upd_valid && upd_ready && !flush;
    status    = {24'b0, pending, seq_err, overflow, 5'(count)};
  end

  assign upd_valid = (count != '0);
  assign {upd_src, upd_dst, upd_e} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {pend_src, pend_dst, writedata};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      pending <= 1'b0;
    end else if (flush) begin
      count   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      pending <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
      if (wr_en && address == 3'd0)
        pending <= 1'b1;
      else if (wr_w)
        pending <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && address == 3'd0) begin
      pend_src <= writedata[2*NODE_BITS-1:NODE_BITS];
      pend_dst <= writedata[NODE_BITS-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
      seq_err  <= 1'b0;
    end else begin
      if (drop_full)
        overflow <= 1'b1;
      else if (wr_en && address == 3'd2 && writedata[0])
        overflow <= 1'b0;
      if (drop_seq)
        seq_err <= 1'b1;
      else if (wr_en && address == 3'd2 && writedata[1])
        seq_err <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      readdata <= '0;
    else if (chipselect && read)
      readdata <= (address == 3'd2) ? status : 32'd0;
  end

endmodule

// File: tb/tb_edge_update_queue.sv
// Directed bench for edge_update_queue: vector table plus
// hand-written ordering, overflow, flush and reset sequences.
module tb_edge_update_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        chipselect;
  logic        write;
  logic        read;
  logic [2:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        upd_valid;
  logic        upd_ready;
  logic [4:0]  upd_src;
  logic [4:0]  upd_dst;
  logic [31:0] upd_e;
  logic [4:0]  count;
  logic        overflow;
  logic        seq_err;

  int total = 0;
  int bad   = 0;

  edge_update_queue dut (
    .clk(clk), .reset(reset),
    .chipselect(chipselect), .write(write), .read(read),
    .address(address), .writedata(writedata), .readdata(readdata),
    .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_src(upd_src), .upd_dst(upd_dst), .upd_e(upd_e),
    .count(count), .overflow(overflow), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] wd;
    logic        rdy;
    logic        v;
    logic [4:0]  cnt;
    logic [4:0]  s;
    logic [4:0]  d;
    logic [31:0] e;
    logic        ovf;
    logic        seq;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, a, x);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic wr, input logic rd, input logic [2:0] a,
                    input logic [31:0] wd, input logic rdy);
    chipselect = wr | rd;
    write      = wr;
    read       = rd;
    address    = a;
    writedata  = wd;
    upd_ready  = rdy;
    tick();
    chipselect = 1'b0;
    write      = 1'b0;
    read       = 1'b0;
    upd_ready  = 1'b0;
  endtask

  task automatic push(input logic [4:0] s, input logic [4:0] d,
                      input logic [31:0] w);
    op(1'b1, 1'b0, 3'd0, {22'd0, s, d}, 1'b0);
    op(1'b1, 1'b0, 3'd1, w, 1'b0);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 3'd0, 32'h43,       1'b0, 1'b0, 5'd0, 5'd0, 5'd0,  32'd0,        1'b0, 1'b0};
    tbl[1]  = '{1'b1, 3'd1, 32'hFFFFFF10, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3,  32'hFFFFFF10, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 3'd0, 32'h0,        1'b1, 1'b0, 5'd0, 5'd0, 5'd0,  32'd0,        1'b0, 1'b0};
    tbl[3]  = '{1'b1, 3'd1, 32'h5,        1'b0, 1'b0, 5'd0, 5'd0, 5'd0,  32'd0,        1'b0, 1'b1};
    tbl[4]  = '{1'b1, 3'd0, 32'h21,       1'b0, 1'b0, 5'd0, 5'd0, 5'd0,  32'd0,        1'b0, 1'b1};
    tbl[5]  = '{1'b1, 3'd0, 32'h8A,       1'b0, 1'b0, 5'd0, 5'd0, 5'd0,  32'd0,        1'b0, 1'b1};
    tbl[6]  = '{1'b1, 3'd1, 32'h77,       1'b0, 1'b1, 5'd1, 5'd4, 5'd10, 32'h77,       1'b0, 1'b1};
    tbl[7]  = '{1'b1, 3'd2, 32'h2,        1'b0, 1'b1, 5'd1, 5'd4, 5'd10, 32'h77,       1'b0, 1'b0};
    tbl[8]  = '{1'b0, 3'd0, 32'h0,        1'b1, 1'b0, 5'd0, 5'd0, 5'd0,  32'd0,        1'b0, 1'b0};
    tbl[9]  = '{1'b1, 3'd0, 32'h43,       1'b1, 1'b0, 5'd0, 5'd0, 5'd0,  32'd0,        1'b0, 1'b0};
    tbl[10] = '{1'b1, 3'd1, 32'h55,       1'b1, 1'b1, 5'd1, 5'd2, 5'd3,  32'h55,       1'b0, 1'b0};
    tbl[11] = '{1'b0, 3'd0, 32'h0,        1'b1, 1'b0, 5'd0, 5'd0, 5'd0,  32'd0,        1'b0, 1'b0};

    reset = 1'b1;
    chipselect = 1'b0; write = 1'b0; read = 1'b0;
    address = 3'd0; writedata = 32'd0; upd_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();

    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(upd_valid), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_seq", 32'(seq_err), 32'd0);
    chk("rst_rdata", readdata, 32'd0);

    for (int i = 0; i < 12; i++) begin
      op(tbl[i].wr, 1'b0, tbl[i].addr, tbl[i].wd, tbl[i].rdy);
      chk($sformatf("v%0d_valid", i), 32'(upd_valid), 32'(tbl[i].v));
      chk($sformatf("v%0d_count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(tbl[i].ovf));
      chk($sformatf("v%0d_seq", i), 32'(seq_err), 32'(tbl[i].seq));
      if (tbl[i].v) begin
        chk($sformatf("v%0d_src", i), 32'(upd_src), 32'(tbl[i].s));
        chk($sformatf("v%0d_dst", i), 32'(upd_dst), 32'(tbl[i].d));
        chk($sformatf("v%0d_e", i), upd_e, tbl[i].e);
      end
    end

    // ordering across pointer wrap
    for (int blk = 0; blk < 2; blk++) begin
      for (int i = 1; i <= 16; i++)
        push(5'(i), 5'(31 - i), 32'(blk * 16 + i));
      chk("ord_peak", 32'(count), 32'd16);
      for (int i = 1; i <= 16; i++) begin
        chk($sformatf("ord_e%0d", blk * 16 + i), upd_e, 32'(blk * 16 + i));
        chk($sformatf("ord_s%0d", blk * 16 + i), 32'(upd_src), 32'(i));
        op(1'b0, 1'b0, 3'd0, 32'd0, 1'b1);
      end
      chk("ord_empty", 32'(upd_valid), 32'd0);
      chk("ord_flags", {30'd0, seq_err, overflow}, 32'd0);
    end

    // overflow
    for (int i = 0; i < 16; i++)
      push(5'd1, 5'd2, 32'(100 + i));
    push(5'd3, 5'd4, 32'd99);
    chk("ovf_count", 32'(count), 32'd16);
    chk("ovf_flag", 32'(overflow), 32'd1);
    op(1'b0, 1'b1, 3'd2, 32'd0, 1'b0);
    chk("ovf_rdata", readdata, 32'h30);
    op(1'b0, 1'b1, 3'd5, 32'd0, 1'b0);
    chk("rd_other", readdata, 32'd0);
    op(1'b1, 1'b0, 3'd2, 32'd1, 1'b0);
    chk("ovf_clear", 32'(overflow), 32'd0);

    // full with simultaneous pop: push still rejected
    op(1'b1, 1'b0, 3'd0, 32'h43, 1'b0);
    op(1'b1, 1'b0, 3'd1, 32'd98, 1'b1);
    chk("fp_count", 32'(count), 32'd15);
    chk("fp_ovf", 32'(overflow), 32'd1);
    chk("fp_head", upd_e, 32'd101);

    // flush with concurrent pop
    op(1'b1, 1'b0, 3'd3, 32'd0, 1'b0);
    chk("fl0_count", 32'(count), 32'd0);
    for (int i = 0; i < 5; i++)
      push(5'd7, 5'd8, 32'(200 + i));
    chk("fl_pre", 32'(count), 32'd5);
    op(1'b1, 1'b0, 3'd3, 32'd0, 1'b1);
    chk("fl_count", 32'(count), 32'd0);
    chk("fl_valid", 32'(upd_valid), 32'd0);
    chk("fl_sticky", 32'(overflow), 32'd1);
    push(5'd9, 5'd10, 32'd300);
    chk("fl_after", upd_e, 32'd300);
    op(1'b1, 1'b0, 3'd3, 32'd0, 1'b0);

    // reset between the two halves of an update
    op(1'b1, 1'b0, 3'd0, 32'h43, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rs_ovf", 32'(overflow), 32'd0);
    op(1'b1, 1'b0, 3'd1, 32'd7, 1'b0);
    chk("rs_seq", 32'(seq_err), 32'd1);
    chk("rs_count", 32'(count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
